// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter datapath: digit limit, the counter
// state type and the nibble-validity check used on load values.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold
  } bcd_state_e;

  // True when the nibble is a legal BCD digit.
  function automatic logic bcd_nibble_valid(input logic [3:0] nib);
    return nib <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_counter_if.sv
// Control/status bundle of the BCD down counter. The controller drives
// load/start/pause; the counter drives the count and its status pulses.
interface bcd_down_counter_if #(
  parameter int unsigned DIGITS = 2
);

  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   Q_out;
  logic                  busy;
  logic                  done;
  logic                  load_err;

  modport master (
    output load, load_val, start, pause,
    input  Q_out, busy, done, load_err
  );

  modport slave (
    input  load, load_val, start, pause,
    output Q_out, busy, done, load_err
  );

endinterface

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement chain. borrow_in requests a decrement of this
// digit; a digit at 0 wraps to 9 and passes the borrow on.
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] digit_next,
  output logic       borrow_out
);

  // Decrement with wrap 0 -> 9 when a borrow arrives.
  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_next = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer: load a BCD value, count down one unit per
// clock while running, pulse done at terminal count.
// Optional feature macro: BCD_DOWN_AUTO_RELOAD_EN (restart from the last
// loaded value after each terminal count).
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic              clk,
  input  logic              rst_asyn,
  bcd_down_counter_if.slave bus
);

  localparam int unsigned W = 4 * DIGITS;

  bcd_state_e state_q, state_d;
  logic [W-1:0] q_q, q_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
  logic [W-1:0] reload_q, reload_d;
`endif

  logic [W-1:0]    dec_val;
  logic [DIGITS:0] borrow;
  logic            q_zero;
  logic            load_ok;

  // Digit 0 always sees a borrow, so the chain's final borrow_out is set
  // exactly when every digit is zero.
  assign borrow[0] = 1'b1;
  assign q_zero    = borrow[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_dec u_digit (
      .digit      (q_q[4*g +: 4]),
      .borrow_in  (borrow[g]),
      .digit_next (dec_val[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  // Every nibble of the load value must be a legal BCD digit.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      load_ok = load_ok & bcd_nibble_valid(bus.load_val[4*i +: 4]);
    end
  end

  // Next-state: load has priority over start, start over pause/count.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.load) begin
      if (load_ok) begin
        q_d     = bus.load_val;
        state_d = StIdle;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
        reload_d = bus.load_val;
`endif
      end else begin
        err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (q_zero) begin
              done_d = 1'b1;
            end else begin
              state_d = StRun;
            end
          end
        end
        StRun, StHold: begin
          if (bus.pause) begin
            state_d = StHold;
          end else begin
            state_d = StRun;
            if (q_zero) begin
              // Only reachable after an auto-reload terminal count.
`ifdef BCD_DOWN_AUTO_RELOAD_EN
              if (reload_q == '0) begin
                state_d = StIdle;
              end else begin
                q_d = reload_q;
              end
`else
              state_d = StIdle;
`endif
            end else begin
              q_d = dec_val;
              if (dec_val == '0) begin
                done_d = 1'b1;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
                if (reload_q == '0) begin
                  state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst_asyn) begin
    if (rst_asyn) begin
      state_q <= StIdle;
      q_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.Q_out    = q_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.load_err = err_q;

endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

Multi-digit BCD down counter (countdown timer) that complements the existing BCD up counter: it is loaded with a BCD value, counts down one unit per clock while running, and flags terminal count. It sits beside the up counter in the display/timer datapath. Its Q_out bus feeds the same digit-display path.

## Interface
Parameters:
- DIGITS, 2, number of BCD digits (1..8); digit 0 is the least significant, at Q_out[3:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_asyn  in  1  asynchronous, active-high reset.
- load  in  1  load request, sampled at the rising edge.
- load_val  in  4*DIGITS  BCD value to load.
- start  in  1  begin countdown, sampled at the rising edge.
- pause  in  1  level; freezes the count while high in RUN/HOLD.
- Q_out  out  4*DIGITS  current count, registered.
- busy  out  1  high in RUN and HOLD.
- done  out  1  one-cycle pulse on terminal count.
- load_err  out  1  one-cycle pulse when load_val contains a nibble greater than 9.

## Operation
- States: IDLE, RUN, HOLD.
- Reset (async): Q_out=0, busy=0, done=0, load_err=0, state=IDLE, reload register=0.
- Load, any state:
  - If every nibble is ≤9: Q_out<=load_val; state<=IDLE; reload register<=load_val.
  - Otherwise: Q_out and state are unchanged; load_err=1 for one cycle.
- Priority: load > start > pause. A simultaneous load+start performs the load only.
- IDLE + start:
  - Q_out≠0: go to RUN.
  - Q_out==0: done pulses for one cycle next cycle; stay in IDLE.
- RUN, pause=0: one BCD decrement per edge.
  - Digit 0 decrements. A digit at 0 with borrow-in wraps to 9 and borrows from the next digit.
  - Never passes below 0.
- RUN + pause=1: go to HOLD; Q_out frozen. HOLD + pause=0: back to RUN with no lost count.
- Terminal count: the edge that takes Q_out from 1 to 0 also sets done=1 for that cycle and returns state to IDLE (see Configuration).
- start while busy: ignored.

## Timing
- Start latency: start sampled at edge N enters RUN; the first decrement happens at edge N+1. A load of V (≠0) started at edge N gives Q_out==0 and done=1 after edge N+V.
- done and load_err are registered and high for exactly one cycle.
- busy falls on the same edge on which done rises.
- Pause takes effect at the edge where it is sampled; that edge produces no decrement.
- Reset mid-count: outputs clear immediately, without waiting for a clock edge. The first edge after rst_asyn deasserts stays in IDLE.

## Configuration
- BCD_DOWN_AUTO_RELOAD_EN, defined:
  - At terminal count, state stays RUN. Q_out shows 0 for one cycle (done=1), then reloads from the reload register on the next edge and continues.
  - If the reload register holds 0, the counter goes to IDLE instead.
  - Only load, or reset, stops auto-reload.
- Not defined: the reload register is omitted and terminal count always returns to IDLE with Q_out=0.

## Structure
- Shared package bcd_pkg holds:
  - BCD_MAX = 4'd9.
  - The state typedef (IDLE, RUN, HOLD).
  - The nibble-validity function used by load checking.
- Sub-module bcd_digit_dec: one 4-bit digit with enable/borrow_in, next-digit value, and borrow_out.
  - Instantiate DIGITS copies in a generate loop, chained on borrow.
  - The top level owns the FSM, load checking, and output registers.

## Test plan
- Reset: assert rst_asyn between clock edges -> Q_out=0, busy=0, done=0 with no clock edge; hold 3 cycles and confirm IDLE.
- Basic countdown, DIGITS=2: load 8'h12, start -> Q_out goes 12,11,10,09,…,01,00. done=1 in the 00 cycle, exactly 12 edges after start was sampled. busy then drops.
- Digit wrap and pause: load 8'h20, start, count to 8'h10. Assert pause 3 cycles -> Q_out holds 10. Release -> next values 09, 08.
- Invalid load: load 8'h1A -> load_err one cycle, Q_out unchanged. Load+start together with 8'h05 -> Q_out=05, state IDLE, no decrement.
- Reset mid-count: load 8'h50, start, assert rst_asyn at Q_out=8'h47 -> immediate Q_out=0, busy=0. Start with Q_out=0 after reset -> done pulse, busy stays 0.
- With BCD_DOWN_AUTO_RELOAD_EN: load 8'h03, start -> sequence 02,01,00(done),03,02,01,00(done),…; a load of 8'h05 mid-sequence -> IDLE at 05.
